// File: rtl/fifo_stream_adapter_if.sv
// FIFO read port plus valid/ready output stream seen by fifo_stream_adapter.
// master: the adapter; slave: the FIFO/consumer side.
interface fifo_stream_adapter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rd_data;
  logic             fifo_rd_en;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    input  fifo_empty, fifo_rd_data, out_ready,
    output fifo_rd_en, out_valid, out_data
  );

  modport slave (
    output fifo_empty, fifo_rd_data, out_ready,
    input  fifo_rd_en, out_valid, out_data
  );
endinterface

// File: rtl/fifo_stream_adapter.sv
// Read-side adapter: turns the FIFO's one-cycle-latency read port into a
// valid/ready stream using a 2-entry holding buffer and read-credit tracking.
module fifo_stream_adapter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  fifo_stream_adapter_if.master bus,
  output logic [CNT_W-1:0]      xfer_count
);

  logic [1:0][WIDTH-1:0] buf_q, buf_d;
  logic                  head_q, head_d;
  logic [1:0]            count_q, count_d;
  logic                  inflight_q, inflight_d;
  logic [CNT_W-1:0]      xfer_q, xfer_d;

  logic       valid;
  logic       pop;
  logic       rd_en;
  logic [2:0] credit_used;
  logic       wr_idx;

  // Output stream and read issue; credit counts buffered plus in-flight words.
  always_comb begin
    valid          = (count_q != 2'd0);
    pop            = valid & bus.out_ready;
    credit_used    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_en          = ~bus.fifo_empty & ~flush & ~reset & (credit_used < 3'd2);
    bus.out_valid  = valid;
    bus.out_data   = buf_q[head_q];
    bus.fifo_rd_en = rd_en;
  end

  // Next-state: capture returning word, advance head on pop, flush discards.
  always_comb begin
    buf_d      = buf_q;
    head_d     = head_q;
    count_d    = count_q;
    inflight_d = rd_en;
    xfer_d     = xfer_q;
    // The free slot sits right behind the last live entry; a same-cycle pop
    // moves head but leaves that slot where it is.
    wr_idx     = head_q ^ count_q[0];
    if (pop && (xfer_q != {CNT_W{1'b1}})) begin
      xfer_d = xfer_q + CNT_W'(1);
    end
    if (flush) begin
      head_d     = 1'b0;
      count_d    = 2'd0;
      inflight_d = 1'b0;
    end else begin
      if (inflight_q) begin
        buf_d[wr_idx] = bus.fifo_rd_data;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q      <= '0;
      head_q     <= 1'b0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      xfer_q     <= '0;
    end else begin
      buf_q      <= buf_d;
      head_q     <= head_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      xfer_q     <= xfer_d;
    end
  end

  assign xfer_count = xfer_q;

endmodule
